// File: rtl/bram_window_reader_if.sv
// Bundle of the command, BRAM read port and window output signals for
// bram_window_reader.
//   master : command issuer / BRAM / window consumer side
//   slave  : bram_window_reader side
// Signals: start, base_addr[19:0], width[9:0], height[9:0] (command);
//          busy, done, err (status); rd_en, rd_we, rd_addr[19:0], rd_data[7:0]
//          (BRAM port); win_valid, win_data[71:0], win_row[9:0], win_col[9:0]
//          (window stream).
interface bram_window_reader_if;
  logic        start;
  logic [19:0] base_addr;
  logic [9:0]  width;
  logic [9:0]  height;
  logic        busy;
  logic        done;
  logic        err;
  logic        rd_en;
  logic        rd_we;
  logic [19:0] rd_addr;
  logic [7:0]  rd_data;
  logic        win_valid;
  logic [71:0] win_data;
  logic [9:0]  win_row;
  logic [9:0]  win_col;

  modport master (
    output start, base_addr, width, height, rd_data,
    input  busy, done, err, rd_en, rd_we, rd_addr, win_valid, win_data, win_row, win_col
  );

  modport slave (
    input  start, base_addr, width, height, rd_data,
    output busy, done, err, rd_en, rd_we, rd_addr, win_valid, win_data, win_row, win_col
  );
endinterface

// File: rtl/bram_window_reader.sv
// Streams an H x W 8-bit map out of a read-only BRAM port in row-major order
// and emits every fully-interior 3x3 window (stride 1, no padding).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : bram_window_reader_if.slave (command, BRAM port, window stream)
// Window byte 3*i+j sits at win_data[8k+7:8k]; i=0 is the oldest row, j=0 the
// leftmost column. win_row/win_col give the window centre.
module bram_window_reader #(
  parameter int MAX_W  = 256,
  parameter int RD_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  bram_window_reader_if.slave bus
);
  localparam int CW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]  w_q, h_q;       // geometry latched on start
  logic [9:0]  r_cnt, c_cnt;   // position of the pixel being issued
  logic        last_pix;
  logic        geom_bad;

  // Tag pipeline: stage s holds the tag of the read issued s cycles ago,
  // so stage RD_LAT lines up with the returning rd_data.
  logic [RD_LAT:1]       vld_pipe;
  logic [RD_LAT:1][9:0]  row_pipe;
  logic [RD_LAT:1][9:0]  col_pipe;

  logic          a_vld;
  logic [9:0]    a_r, a_c;
  logic [CW-1:0] a_idx;

  logic [7:0] lb0 [MAX_W];    // row r-1
  logic [7:0] lb1 [MAX_W];    // row r-2
  logic [7:0] lb0_rd, lb1_rd;

  logic [2:0][2:0][7:0] win;  // [row i][col j][byte]

  assign geom_bad = (bus.width < 10'd3) || (bus.height < 10'd3) ||
                    (bus.width > 10'(MAX_W));
  assign last_pix = (r_cnt == h_q - 10'd1) && (c_cnt == w_q - 10'd1);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.rd_en = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = geom_bad ? DONE : READ;
      READ: begin
        bus.busy  = 1'b1;
        bus.rd_en = 1'b1;
        if (last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        // Last window is registered the cycle the tag pipe empties, so
        // leaving now puts done right after the final win_valid.
        if (vld_pipe == '0) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_we = 1'b0;

  // ---------------- issue side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      h_q         <= '0;
      r_cnt       <= '0;
      c_cnt       <= '0;
      bus.rd_addr <= '0;
      bus.err     <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      w_q         <= bus.width;
      h_q         <= bus.height;
      r_cnt       <= '0;
      c_cnt       <= '0;
      bus.rd_addr <= bus.base_addr;
      bus.err     <= geom_bad;
    end else if (state == READ && !last_pix) begin
      bus.rd_addr <= bus.rd_addr + 20'd1;  // wraps modulo 2^20
      if (c_cnt == w_q - 10'd1) begin
        c_cnt <= '0;
        r_cnt <= r_cnt + 10'd1;
      end else begin
        c_cnt <= c_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      row_pipe <= '0;
      col_pipe <= '0;
    end else begin
      vld_pipe[1] <= bus.rd_en;
      row_pipe[1] <= r_cnt;
      col_pipe[1] <= c_cnt;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        row_pipe[s] <= row_pipe[s-1];
        col_pipe[s] <= col_pipe[s-1];
      end
    end
  end

  // ---------------- arrival side ----------------
  assign a_vld = vld_pipe[RD_LAT];
  assign a_r   = row_pipe[RD_LAT];
  assign a_c   = col_pipe[RD_LAT];
  assign a_idx = a_c[CW-1:0];

  // Combinational reads against non-blocking writes: same-column
  // read-modify-write in one cycle sees the old contents.
  assign lb0_rd = lb0[a_idx];
  assign lb1_rd = lb1[a_idx];

  always_ff @(posedge clk) begin
    if (a_vld) begin
      lb1[a_idx] <= lb0_rd;
      lb0[a_idx] <= bus.rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win           <= '0;
      bus.win_valid <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
    end else begin
      bus.win_valid <= 1'b0;
      if (a_vld) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= bus.rd_data;
        // c>=2 keeps all three columns inside the current row.
        if (a_r >= 10'd2 && a_c >= 10'd2) begin
          bus.win_valid <= 1'b1;
          bus.win_row   <= a_r - 10'd1;
          bus.win_col   <= a_c - 10'd1;
        end
      end
    end
  end

  assign bus.win_data = win;
endmodule

// File: tb/tb_bram_window_reader.sv
module tb_bram_window_reader;
  localparam int MAX_W  = 256;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [71:0] first_win, last_win;

  bram_window_reader_if bus ();

  bram_window_reader #(.MAX_W(MAX_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: mem[a] = a[7:0], two-cycle read latency.
  logic [7:0] p1;
  always @(posedge clk) begin
    p1          <= bus.rd_en ? bus.rd_addr[7:0] : 8'hA5;
    bus.rd_data <= p1;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [7:0] pix(input int b, input int w, input int r, input int c);
    int a;
    a = b + r * w + c;
    return a[7:0];
  endfunction

  task automatic chk_zero(input int t);
    chk($sformatf("rst busy t=%0d", t), bus.busy, 1'b0);
    chk($sformatf("rst done t=%0d", t), bus.done, 1'b0);
    chk($sformatf("rst err t=%0d", t), bus.err, 1'b0);
    chk($sformatf("rst rd_en t=%0d", t), bus.rd_en, 1'b0);
    chk($sformatf("rst rd_we t=%0d", t), bus.rd_we, 1'b0);
    chk($sformatf("rst rd_addr t=%0d", t), bus.rd_addr, 20'd0);
    chk($sformatf("rst win_valid t=%0d", t), bus.win_valid, 1'b0);
    chk($sformatf("rst win_data t=%0d", t), bus.win_data, 72'd0);
    chk($sformatf("rst win_row t=%0d", t), bus.win_row, 10'd0);
    chk($sformatf("rst win_col t=%0d", t), bus.win_col, 10'd0);
  endtask

  // One run, checked every cycle against the documented timing:
  // pixel k issued in cycle 1+k, its window in cycle 4+k, done in W*H+4.
  task automatic run(input logic [19:0] b, input int w, input int h,
                     input int restart_at, input int rst_at);
    int wh, nwin, ndone, k, r, c;
    logic exp_v;
    logic [71:0] exp_win;
    logic [19:0] exp_addr;
    wh = w * h; nwin = 0; ndone = 0;
    @(negedge clk);
    bus.base_addr = b; bus.width = 10'(w); bus.height = 10'(h); bus.start = 1'b1;
    for (int t = 1; t <= wh + 6; t++) begin
      @(negedge clk);
      if (t == 1) bus.start = 1'b0;
      if (rst_at != 0 && t == rst_at + 1) begin
        chk_zero(t);
        rst = 1'b0;
      end else if (rst_at != 0 && t > rst_at + 1) begin
        chk($sformatf("post-rst done t=%0d", t), bus.done, 1'b0);
        chk($sformatf("post-rst win_valid t=%0d", t), bus.win_valid, 1'b0);
        chk($sformatf("post-rst rd_en t=%0d", t), bus.rd_en, 1'b0);
      end else begin
        chk($sformatf("rd_en t=%0d", t), bus.rd_en, t <= wh);
        if (t <= wh) begin
          exp_addr = b + 20'(t - 1);
          chk($sformatf("rd_addr t=%0d", t), bus.rd_addr, exp_addr);
        end
        chk($sformatf("rd_we t=%0d", t), bus.rd_we, 1'b0);
        k = t - 4; r = (k >= 0) ? k / w : 0; c = (k >= 0) ? k % w : 0;
        exp_v = (k >= 0) && (k < wh) && (r >= 2) && (c >= 2);
        chk($sformatf("win_valid t=%0d", t), bus.win_valid, exp_v);
        if (exp_v) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp_win[8*(3*i+j) +: 8] = pix(int'(b), w, r - 2 + i, c - 2 + j);
          chk($sformatf("win_data t=%0d", t), bus.win_data, exp_win);
          chk($sformatf("win_row t=%0d", t), bus.win_row, 10'(r - 1));
          chk($sformatf("win_col t=%0d", t), bus.win_col, 10'(c - 1));
          if (r == 2 && c == 2) first_win = bus.win_data;
          last_win = bus.win_data;
        end
        chk($sformatf("done t=%0d", t), bus.done, t == wh + 4);
        chk($sformatf("busy t=%0d", t), bus.busy, t < wh + 4);
        chk($sformatf("err t=%0d", t), bus.err, 1'b0);
        if (bus.win_valid) nwin++;
        if (bus.done) ndone++;
      end
      if (t == restart_at) begin
        bus.start = 1'b1; bus.base_addr = 20'h0; bus.width = 10'd3; bus.height = 10'd3;
      end
      if (restart_at != 0 && t == restart_at + 1) bus.start = 1'b0;
      if (t == rst_at) rst = 1'b1;
    end
    if (rst_at == 0) begin
      chk("window count", 32'(nwin), 32'((w - 2) * (h - 2)));
      chk("done count", 32'(ndone), 32'd1);
    end
  endtask

  task automatic bad_geom(input int w, input int h);
    @(negedge clk);
    bus.base_addr = 20'h40; bus.width = 10'(w); bus.height = 10'(h); bus.start = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) bus.start = 1'b0;
      chk($sformatf("bad done w=%0d t=%0d", w, t), bus.done, t == 1);
      chk($sformatf("bad err w=%0d t=%0d", w, t), bus.err, 1'b1);
      chk($sformatf("bad rd_en w=%0d t=%0d", w, t), bus.rd_en, 1'b0);
      chk($sformatf("bad busy w=%0d t=%0d", w, t), bus.busy, 1'b0);
      chk($sformatf("bad win_valid w=%0d t=%0d", w, t), bus.win_valid, 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.width = '0; bus.height = '0;
    repeat (3) @(negedge clk);
    chk_zero(0);
    rst = 1'b0;

    // Basic 4x4; windows at cycles 14,15,18,19, done at 20.
    run(20'h00100, 4, 4, 0, 0);
    chk("4x4 first window", first_win, 72'h0A0908060504020100);
    chk("4x4 last window", last_win, 72'h0F0E0D0B0A09070605);

    // Address wrap.
    run(20'hFFFFE, 3, 3, 0, 0);
    chk("wrap window", last_win, 72'h060504030201_00FFFE);

    // Bad geometry, then a good start clears err.
    bad_geom(2, 5);
    run(20'h00000, 3, 3, 0, 0);
    bad_geom(MAX_W + 1, 3);
    bad_geom(5, 2);

    // Start while busy is ignored (new geometry presented mid-READ).
    run(20'h00020, 5, 5, 5, 0);

    // Reset in cycle 6 of an 8x8 run, then a full 8x8 run.
    run(20'h00200, 8, 8, 0, 6);
    run(20'h00300, 8, 8, 0, 0);

    // Maximum width.
    run(20'h00000, MAX_W, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_window_reader.md
Name: bram_window_reader

Overview:
- Downstream consumer of the 8-bit feature-map BRAM.
- Drives the BRAM's byte-wide data port (ena/wea/addra) in read-only mode and streams an H x W single-channel map out in row-major order.
- Assembles 3x3 sliding windows (stride 1, no padding) using two internal line buffers.
- Emits one 72-bit window per valid output position to the convolution datapath, with a start/done command handshake.

Parameters:
- MAX_W, 256: maximum map width; sets line buffer depth.
- RD_LAT, 2: cycles from rd_en/rd_addr asserted to rd_data valid; fixed pipeline, no stall.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle command pulse; sampled only in IDLE
- base_addr  in  20  byte address of pixel (0,0)
- width  in  10  map width W in pixels
- height  in  10  map height H in pixels
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle completion pulse
- err  out  1  registered; set on bad geometry, cleared on next accepted start
- rd_en  out  1  BRAM port enable (to data_ena)
- rd_we  out  1  always 0 (to data_wea)
- rd_addr  out  20  BRAM byte address (to data_addra)
- rd_data  in  8  BRAM read data (from vgg16_bram_douta)
- win_valid  out  1  window output strobe
- win_data  out  72  3x3 window; byte k = 3*i+j at bits [8k+7:8k]
  - i = row offset: 0 is row r-2 (oldest), 2 is row r
  - j = column offset: 0 is column c-2, 2 is column c
- win_row  out  10  window-centre row, r-1
- win_col  out  10  window-centre column, c-1

Behaviour:
- Reset: state IDLE; busy, done, err, rd_en, rd_we, win_valid = 0; rd_addr, win_data, win_row, win_col = 0; all counters and the tag pipeline cleared. Reset mid-operation aborts immediately; no done is issued.
- Start acceptance: start is accepted in IDLE only. start while busy is ignored. Geometry is latched on acceptance; later changes to width/height/base_addr have no effect on the run in progress.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- Geometry check: width<3, height<3 or width>MAX_W means bad geometry.
  - No reads are issued.
  - FSM goes IDLE -> DONE.
  - err=1 and done=1 in the same cycle, cycle 1 after start.
- READ:
  - rd_en=1 every cycle.
  - rd_addr = base_addr + k, where k = linear pixel index 0..W*H-1. Addition is modulo 2^20 (wraps).
  - Row/column counters (r, c) advance with k; c wraps at W-1.
  - Pixel k is issued in cycle 1+k after start.
  - After issuing k = W*H-1, go to DRAIN with rd_en=0.
- DRAIN: hold RD_LAT cycles until the tag pipeline is empty, then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Tag pipeline: an RD_LAT-deep shift register carries {valid, r, c} alongside each read so arriving rd_data is tagged.
- Per arriving pixel p at (r, c):
  - Column c of line buffer 0 (row r-1) is read together with column c of line buffer 1 (row r-2).
  - Column c of line buffer 1 is overwritten with line buffer 0's old value.
  - Column c of line buffer 0 is overwritten with p.
  - The 3x3 window register shifts left one column; new column = {lb1, lb0, p}.
  - A read-before-write on the same column in the same cycle must return the old data.
- Window output:
  - win_valid=1 in the cycle after a pixel with r>=2 and c>=2 arrives (registered output).
  - Window columns straddling a row boundary are never emitted.
  - Output count = (W-2)*(H-2).
- Latency: pixel k's window is output in cycle 2+k+RD_LAT after start; done is asserted the cycle after the last win_valid.
- No backpressure: downstream must accept one window per cycle.

Test Plan:
- Basic 4x4 map: mem[0x100+k]=k, base=0x100, W=H=4, RD_LAT=2 -> 4 windows at cycles 14,15,18,19.
  - First window bytes k0..k8 = 00,01,02,04,05,06,08,09,0A with row/col=(1,1).
  - Last window = 05,06,07,09,0A,0B,0D,0E,0F.
  - done at cycle 20; rd_addr sweeps 0x100..0x10F in cycles 1..16.
- Address wrap: base=0xFFFFE, W=3, H=3 -> rd_addr sequence FFFFE, FFFFF, 00000 .. 00006; exactly 1 window.
- Bad geometry: W=2, H=5 -> no rd_en; err=1 and done=1 at cycle 1; win_valid never asserted. A following valid start clears err.
- Start while busy: a second start in mid-READ on a 5x5 run -> ignored; exactly 9 windows and one done.
- Reset mid-run: rst in cycle 6 of an 8x8 run -> all outputs 0 on the next cycle; no done. A restarted 8x8 run yields 36 correct windows.
- Max width: W=MAX_W, H=3, mem[k]=k mod 256 -> 254 windows; each is byte-exact against a reference model; win_col 1..254.
